// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg
//   Shared constants for the instruction fetch slice: address/data widths, memory
//   base and reset PC, default fetch queue depth and the per-instruction PC step.
//   Imported by ifu_fq and ifu_fetch.
//   Optional feature macro used by this slice: IFU_PERF_CNT_EN (see ifu_fetch).
package ifu_fetch_pkg;

    localparam int          ADDR_WIDTH = 32;
    localparam int          DATA_WIDTH = 32;
    localparam logic [31:0] MEM_BASE   = 32'h8000_0000;
    localparam logic [31:0] RESET_PC   = MEM_BASE;
    localparam int          FQ_DEPTH   = 2;
    localparam int          INSTR_STEP = 4;

endpackage

// File: rtl/ifu_fq.sv
// ifu_fq
//   Synchronous FIFO holding {pc, instr} pairs for the fetch stage.
//   Flush overrides push and pop. Head outputs come straight from storage registers.
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   push, wr_pc,    write {wr_pc, wr_instr} at the tail
//   wr_instr
//   pop             advance the head
//   flush           empty the queue
//   rd_pc, rd_instr head entry
//   full, empty     occupancy flags
module ifu_fq
    import ifu_fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int AW    = ADDR_WIDTH,
    parameter int DW    = DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [AW-1:0] wr_pc,
    input  logic [DW-1:0] wr_instr,
    output logic [AW-1:0] rd_pc,
    output logic [DW-1:0] rd_instr,
    output logic          full,
    output logic          empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [AW-1:0]    pc_mem    [DEPTH];
    logic [DW-1:0]    instr_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (push && !flush) begin
            pc_mem[wr_ptr]    <= wr_pc;
            instr_mem[wr_ptr] <= wr_instr;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_pc    = pc_mem[rd_ptr];
    assign rd_instr = instr_mem[rd_ptr];
    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch
//   Instruction fetch stage in front of pmem. Holds pc_r, which is the pmem address,
//   captures the combinationally returned word with its PC into ifu_fq, and hands the
//   queue head to decode over valid/ready. A one-cycle redirect from EXU flushes the
//   queue and reloads pc_r with the word-aligned target.
// Optional feature: define IFU_PERF_CNT_EN to add the perf_fetch_o / perf_stall_o
//   counters and ports. With the macro undefined the ports and logic are absent.
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   instr_addr_o        pmem fetch address (= pc_r)
//   instr_i             pmem read data, same cycle as instr_addr_o
//   redirect_valid_i    EXU redirect strobe
//   redirect_pc_i       redirect target (low two bits ignored)
//   ifu_valid_o         queue head valid
//   ifu_ready_i         decode accepts head
//   ifu_pc_o            head PC
//   ifu_instr_o         head instruction
//   perf_fetch_o        pushed-word count        (IFU_PERF_CNT_EN)
//   perf_stall_o        valid & !ready cycles     (IFU_PERF_CNT_EN)
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int          AW       = ADDR_WIDTH,
    parameter int          DW       = DATA_WIDTH,
    parameter logic [31:0] RST_PC   = RESET_PC,
    parameter int          FQ_DEPTH_P = FQ_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [AW-1:0] instr_addr_o,
    input  logic [DW-1:0] instr_i,
    input  logic          redirect_valid_i,
    input  logic [AW-1:0] redirect_pc_i,
    output logic          ifu_valid_o,
    input  logic          ifu_ready_i,
    output logic [AW-1:0] ifu_pc_o,
    output logic [DW-1:0] ifu_instr_o
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]   perf_fetch_o,
    output logic [31:0]   perf_stall_o
`endif
);

    logic [AW-1:0] pc_r;
    logic          fq_full;
    logic          fq_empty;
    logic          pop;
    logic          push;
    logic [1:0]    unused_redirect_lo;

    assign unused_redirect_lo = redirect_pc_i[1:0];

    assign ifu_valid_o = !fq_empty;
    assign pop         = ifu_valid_o && ifu_ready_i;
    // A pop frees a slot this cycle, so a full queue can still take the new word.
    assign push        = !redirect_valid_i && (!fq_full || pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r <= AW'(RST_PC);
        end else if (redirect_valid_i) begin
            pc_r <= {redirect_pc_i[AW-1:2], 2'b00};
        end else if (push) begin
            pc_r <= pc_r + AW'(INSTR_STEP);
        end
    end

    assign instr_addr_o = pc_r;

    // Redirect flushes the queue; flush wins inside ifu_fq so the head is not consumed.
    ifu_fq #(
        .DEPTH (FQ_DEPTH_P),
        .AW    (AW),
        .DW    (DW)
    ) u_fq (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop && !redirect_valid_i),
        .flush    (redirect_valid_i),
        .wr_pc    (pc_r),
        .wr_instr (instr_i),
        .rd_pc    (ifu_pc_o),
        .rd_instr (ifu_instr_o),
        .full     (fq_full),
        .empty    (fq_empty)
    );

`ifdef IFU_PERF_CNT_EN
    // Counters are independent of redirect; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_o <= '0;
            perf_stall_o <= '0;
        end else begin
            if (push)                        perf_fetch_o <= perf_fetch_o + 32'd1;
            if (ifu_valid_o && !ifu_ready_i) perf_stall_o <= perf_stall_o + 32'd1;
        end
    end
`endif

endmodule
